// File: rtl/udp_depacketizer_pkg.sv
// pkt_defs: frame layout shared by the IQ UDP transmitter and receiver.
//   - Byte offsets of every field the receiver checks or extracts, counted
//     from the first destination-MAC byte (index 0).
//   - Expected header field values and the parser state encoding.
//   - Helpers that return the expected value of a header byte.
package pkt_defs;

  localparam logic [10:0] OFS_ETYPE   = 11'h00C;
  localparam logic [10:0] OFS_VER     = 11'h00E;
  localparam logic [10:0] OFS_PROTO   = 11'h017;
  localparam logic [10:0] OFS_DIP     = 11'h01E;
  localparam logic [10:0] OFS_DPORT   = 11'h024;
  localparam logic [10:0] OFS_SEQ     = 11'h02A;
  localparam logic [10:0] OFS_PAYLOAD = 11'h032;
  localparam logic [10:0] LAST_BYTE   = 11'h5E9;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  MAC_BCAST_BYTE = 8'hFF;

  // Parser states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_SEQ     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DROP    = 3'd4;

  // Byte sel (0..5) of a MAC address, most significant byte first on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] sel);
    logic [7:0] b;
    case (sel)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

  // Check one byte at index idx (>= 6) against the fixed IPv4/UDP header
  // fields. Indices that carry no checked field always pass.
  function automatic logic hdr_byte_ok(input logic [10:0] idx, input logic [7:0] data,
                                       input logic [31:0] ip, input logic [15:0] port);
    logic ok;
    ok = 1'b1;
    case (idx)
      OFS_ETYPE:          ok = (data == ETHERTYPE_IPV4[15:8]);
      OFS_ETYPE + 11'd1:  ok = (data == ETHERTYPE_IPV4[7:0]);
      OFS_VER:            ok = (data == IP_VER_IHL);
      OFS_PROTO:          ok = (data == IP_PROTO_UDP);
      OFS_DIP:            ok = (data == ip[31:24]);
      OFS_DIP + 11'd1:    ok = (data == ip[23:16]);
      OFS_DIP + 11'd2:    ok = (data == ip[15:8]);
      OFS_DIP + 11'd3:    ok = (data == ip[7:0]);
      OFS_DPORT:          ok = (data == port[15:8]);
      OFS_DPORT + 11'd1:  ok = (data == port[7:0]);
      default:            ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/udp_depacketizer_iq_word_assembler.sv
// iq_word_assembler: packs payload bytes I[7:0], I[15:8], Q[7:0], Q[15:8]
// into one {I,Q} word and offers it to the sample FIFO the cycle after the
// Q[15:8] byte. A word that meets wr_full is dropped and flagged instead.
//   clk, rst      clock, asynchronous active-low reset
//   sop           frame start; realigns the byte phase to I[7:0]
//   byte_valid    byte_data is a payload byte this cycle
//   byte_data     payload byte
//   wr_full       sample FIFO full (checked in the cycle the word is offered)
//   wr_en         one-cycle write strobe
//   wr_data       {I[15:0],Q[15:0]}
//   overflow      one-cycle pulse: completed word lost to wr_full
module iq_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        sop,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        wr_full,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic        overflow
);

  logic [1:0]  phase;
  logic [15:0] i_word;
  logic [7:0]  q_lo;
  logic        pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= 2'd0;
      i_word  <= 16'd0;
      q_lo    <= 8'd0;
      pend    <= 1'b0;
      wr_data <= 32'd0;
    end else begin
      pend <= 1'b0;
      if (sop) begin
        phase <= 2'd0;
      end else if (byte_valid) begin
        phase <= phase + 2'd1;
        case (phase)
          2'd0:    i_word[7:0]  <= byte_data;
          2'd1:    i_word[15:8] <= byte_data;
          2'd2:    q_lo         <= byte_data;
          default: begin
            wr_data <= {i_word, byte_data, q_lo};
            pend    <= 1'b1;
          end
        endcase
      end
    end
  end

  // The FIFO has no back-pressure path into the MAC, so full turns a write
  // into a loss report in the same cycle rather than stalling.
  assign wr_en    = pend & ~wr_full;
  assign overflow = pend & wr_full;

endmodule

// File: rtl/udp_depacketizer.sv
// udp_depacketizer: receive-side parser for the IQ UDP stream.
// Filters Ethernet/IPv4/UDP frames on destination MAC (or broadcast), IP
// and port, captures the 64-bit little-endian sequence counter and streams
// the I/Q payload into the sample FIFO (cut-through).
//   clk, rst            clock, asynchronous active-low reset
//   rx_data/dv/sop/eop  MAC receive bytes; sop/eop qualified by rx_dv
//   rx_err              frame error, sampled with rx_eop
//   wr_en, wr_data      sample FIFO write strobe and {I,Q} word
//   wr_full             sample FIFO full
//   seq_num             sequence counter of the last accepted frame
//   frames_ok           accepted frames (wraps)
//   frames_drop         filtered/errored/aborted frames (saturates)
//   seq_gap             pulse: accepted seq != previous + 1
//   overflow            pulse: a sample was lost to wr_full
//   dbg_state           parser state
//
// Flow control: a receive byte is transferred in every cycle rx_dv is high;
// there is no ready, so the parser takes a byte each valid cycle and holds
// all state when rx_dv is low. On the FIFO side a word is transferred in a
// cycle with wr_en high; wr_en is never raised while wr_full is high.
module udp_depacketizer
  import pkt_defs::*;
#(
  parameter logic [47:0] LOCAL_MAC         = 48'h021234567890,
  parameter logic [31:0] LOCAL_IP          = {8'd192, 8'd168, 8'd50, 8'd50},
  parameter logic [15:0] LOCAL_PORT        = 16'd32179,
  parameter int          SAMPLES_PER_FRAME = 366
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        rx_err,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  output logic [63:0] seq_num,
  output logic [31:0] frames_ok,
  output logic [15:0] frames_drop,
  output logic        seq_gap,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  localparam logic [10:0] LAST_IDX = 11'(int'(OFS_PAYLOAD) + 4 * SAMPLES_PER_FRAME - 1);

  logic [2:0]  state, state_n;
  logic [10:0] bidx, bidx_n;
  logic        mac_l, mac_b, mac_l_n, mac_b_n;
  logic [63:0] seq_shadow, seq_shadow_n;
  logic        first;
  logic [2:0]  mac_sel;
  logic        hit_l, hit_b, hdr_bad;
  logic        drop_old, drop_new, accept;
  logic        sop_byte, byte_valid;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign sop_byte   = rx_dv & rx_sop;
  assign mac_sel    = rx_sop ? 3'd0 : bidx[2:0];
  assign hit_l      = (rx_data == mac_byte(LOCAL_MAC, mac_sel));
  assign hit_b      = (rx_data == MAC_BCAST_BYTE);
  // Bytes past the last sample are ignored until eop.
  assign byte_valid = rx_dv & ~rx_sop & (state == ST_PAYLOAD) & (bidx <= LAST_IDX);
  assign dbg_state  = state;

  always_comb begin
    state_n      = state;
    bidx_n       = bidx;
    mac_l_n      = mac_l;
    mac_b_n      = mac_b;
    seq_shadow_n = seq_shadow;
    hdr_bad      = 1'b0;
    drop_old     = 1'b0;
    drop_new     = 1'b0;
    accept       = 1'b0;
    if (rx_dv) begin
      if (rx_sop) begin
        // A sop always starts a new frame at index 0; an unfinished frame
        // is abandoned and counted.
        drop_old = (state != ST_IDLE);
        bidx_n   = 11'd1;
        mac_l_n  = hit_l;
        mac_b_n  = hit_b;
        if (rx_eop) begin
          drop_new = 1'b1;
          state_n  = ST_IDLE;
        end else if (!(hit_l || hit_b)) begin
          state_n = ST_DROP;
        end else begin
          state_n = ST_HEADER;
        end
      end else begin
        case (state)
          ST_HEADER: begin
            bidx_n = bidx + 11'd1;
            if (bidx < 11'd6) begin
              // Local and broadcast MAC are tracked separately; the frame
              // survives while either still matches every byte so far.
              mac_l_n = mac_l & hit_l;
              mac_b_n = mac_b & hit_b;
              hdr_bad = ~(mac_l_n | mac_b_n);
            end else begin
              hdr_bad = ~hdr_byte_ok(bidx, rx_data, LOCAL_IP, LOCAL_PORT);
            end
            if (rx_eop) begin
              drop_new = 1'b1;
              state_n  = ST_IDLE;
            end else if (hdr_bad) begin
              state_n = ST_DROP;
            end else if (bidx == OFS_SEQ - 11'd1) begin
              state_n = ST_SEQ;
            end
          end
          ST_SEQ: begin
            bidx_n = bidx + 11'd1;
            // Little-endian: shifting in at the top leaves the first byte in [7:0].
            seq_shadow_n = {rx_data, seq_shadow[63:8]};
            if (rx_eop) begin
              drop_new = 1'b1;
              state_n  = ST_IDLE;
            end else if (bidx == OFS_PAYLOAD - 11'd1) begin
              state_n = ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (bidx != 11'h7FF) bidx_n = bidx + 11'd1;
            if (rx_eop) begin
              state_n = ST_IDLE;
              if ((bidx >= LAST_IDX) && !rx_err) accept = 1'b1;
              else drop_new = 1'b1;
            end
          end
          ST_DROP: begin
            if (rx_eop) begin
              drop_new = 1'b1;
              state_n  = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // An aborting sop that is also a one-byte frame drops two frames at once.
  assign drop_inc = {1'b0, drop_old} + {1'b0, drop_new};
  assign drop_sum = {1'b0, frames_drop} + {15'd0, drop_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bidx        <= 11'd0;
      mac_l       <= 1'b0;
      mac_b       <= 1'b0;
      seq_shadow  <= 64'd0;
      seq_num     <= 64'd0;
      frames_ok   <= 32'd0;
      frames_drop <= 16'd0;
      seq_gap     <= 1'b0;
      first       <= 1'b1;
    end else begin
      state       <= state_n;
      bidx        <= bidx_n;
      mac_l       <= mac_l_n;
      mac_b       <= mac_b_n;
      seq_shadow  <= seq_shadow_n;
      frames_drop <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      seq_gap     <= 1'b0;
      if (accept) begin
        seq_num   <= seq_shadow;
        frames_ok <= frames_ok + 32'd1;
        seq_gap   <= ~first & (seq_shadow != seq_num + 64'd1);
        first     <= 1'b0;
      end
    end
  end

  iq_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .sop        (sop_byte),
    .byte_valid (byte_valid),
    .byte_data  (rx_data),
    .wr_full    (wr_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_udp_depacketizer.sv
// Directed sequence of frames with randomized filler bytes, samples and
// rx_dv gaps, checked against a frame-level reference model.
module tb_udp_depacketizer;
  import pkt_defs::*;

  localparam logic [47:0] LOCAL_MAC  = 48'h021234567890;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFFFFFFFFFF;
  localparam logic [31:0] LOCAL_IP   = {8'd192, 8'd168, 8'd50, 8'd50};
  localparam logic [15:0] LOCAL_PORT = 16'd32179;
  localparam int          NS         = 366;
  localparam int          PAY        = 50;
  localparam int          LAST       = 1513;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  rx_data;
  logic        rx_dv, rx_sop, rx_eop, rx_err, wr_full;
  logic        wr_en, seq_gap, overflow;
  logic [31:0] wr_data, frames_ok;
  logic [63:0] seq_num;
  logic [15:0] frames_drop;
  logic [2:0]  dbg_state;

  udp_depacketizer dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .rx_err(rx_err), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .seq_num(seq_num), .frames_ok(frames_ok),
    .frames_drop(frames_drop), .seq_gap(seq_gap), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  string       cur_test = "reset";
  logic [31:0] exp_q[$];
  int          n_wr = 0, n_ovf = 0, n_gap = 0;
  int          m_wr = 0, m_ovf = 0, m_gap = 0, m_ok = 0, m_drop = 0;
  logic [63:0] m_seq = 64'd0;
  bit          m_first = 1'b1;
  logic [7:0]  frame_q[$];
  logic [15:0] smp_i[NS];
  logic [15:0] smp_q[NS];
  bit          full_next = 1'b0;
  int          full_lo = -1, full_hi = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
    end
  endtask

  // Monitor: sampled mid-low-phase, after the driver's negedge updates.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (wr_en) begin
        n_wr++;
        if (exp_q.size() > 0) chk("wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
      end
      if (overflow) n_ovf++;
      if (seq_gap)  n_gap++;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit dv, input logic [7:0] d, input bit sop, input bit eop, input bit err);
    @(negedge clk);
    wr_full   = full_next;
    full_next = 1'b0;
    rx_dv = dv; rx_data = d; rx_sop = sop; rx_eop = eop; rx_err = err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input int last, input bit with_eop, input bit err);
    int k;
    for (int b = 0; b <= last; b++) begin
      if (b > 0 && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      drive(1'b1, frame_q[b], b == 0, with_eop && b == last, err && with_eop && b == last);
      // wr_full applies in the cycle after a sample's last byte.
      if (b >= PAY && b <= LAST && ((b - PAY) % 4) == 3) begin
        k = (b - PAY) / 4;
        full_next = (k >= full_lo && k <= full_hi);
      end
    end
  endtask

  // ---------------- reference model ----------------
  task automatic fill(input bit ramp);
    for (int k = 0; k < NS; k++) begin
      smp_i[k] = ramp ? 16'(k)  : 16'($urandom);
      smp_q[k] = ramp ? 16'(-k) : 16'($urandom);
    end
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] dport,
                       input logic [63:0] seq, input int extra);
    logic [31:0] ip;
    ip = LOCAL_IP;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(etype[15:8]); frame_q.push_back(etype[7:0]);
    frame_q.push_back(8'h45);
    for (int i = 0; i < 8; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(8'h11);
    for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) frame_q.push_back(ip[31-8*i -: 8]);
    for (int i = 0; i < 2; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(dport[15:8]); frame_q.push_back(dport[7:0]);
    for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) frame_q.push_back(seq[8*i +: 8]);
    for (int k = 0; k < NS; k++) begin
      frame_q.push_back(smp_i[k][7:0]); frame_q.push_back(smp_i[k][15:8]);
      frame_q.push_back(smp_q[k][7:0]); frame_q.push_back(smp_q[k][15:8]);
    end
    for (int i = 0; i < extra; i++) frame_q.push_back(8'($urandom));
  endtask

  function automatic bit hdr_good(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] dport);
    return (dmac == LOCAL_MAC || dmac == BCAST_MAC) && etype == 16'h0800 && dport == LOCAL_PORT;
  endfunction

  // Frame-level expectation: every whole sample received after a good
  // header is written (or lost to full); the frame counts as accepted
  // only with a good header, full length and no error at eop.
  task automatic model(input bit good, input int last, input bit with_eop, input bit err,
                       input logic [63:0] seq);
    if (good) begin
      for (int k = 0; k < NS; k++) begin
        if (PAY + 4 * k + 3 <= last) begin
          if (k >= full_lo && k <= full_hi) m_ovf++;
          else begin exp_q.push_back({smp_i[k], smp_q[k]}); m_wr++; end
        end
      end
    end
    if (with_eop) begin
      if (good && last >= LAST && !err) begin
        if (!m_first && seq != m_seq + 64'd1) m_gap++;
        m_seq = seq; m_ok++; m_first = 1'b0;
      end else begin
        m_drop++;
      end
    end
  endtask

  task automatic check_all();
    chk("wr_count",    64'(n_wr),  64'(m_wr));
    chk("ovf_count",   64'(n_ovf), 64'(m_ovf));
    chk("gap_count",   64'(n_gap), 64'(m_gap));
    chk("seq_num",     seq_num,    m_seq);
    chk("frames_ok",   64'(frames_ok),   64'(m_ok));
    chk("frames_drop", 64'(frames_drop), 64'(m_drop));
    chk("exp_q_left",  64'(exp_q.size()), 64'd0);
    chk("state_idle",  64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic run(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] dport,
                     input logic [63:0] seq, input int extra, input int last,
                     input bit with_eop, input bit err, input bit settle);
    build(dmac, etype, dport, seq, extra);
    model(hdr_good(dmac, etype, dport), last, with_eop, err, seq);
    send(last, with_eop, err);
    if (settle) begin
      idle(6);
      check_all();
    end
  endtask

  task automatic check_zero_outputs();
    chk("rst_wr_en",       64'(wr_en),       64'd0);
    chk("rst_wr_data",     64'(wr_data),     64'd0);
    chk("rst_seq_num",     seq_num,          64'd0);
    chk("rst_frames_ok",   64'(frames_ok),   64'd0);
    chk("rst_frames_drop", 64'(frames_drop), 64'd0);
    chk("rst_seq_gap",     64'(seq_gap),     64'd0);
    chk("rst_overflow",    64'(overflow),    64'd0);
    chk("rst_state",       64'(dbg_state),   64'(ST_IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rx_data = 8'h00; rx_dv = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; wr_full = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero_outputs();
    rst = 1'b1;
    idle(2);

    cur_test = "basic_seq5";
    fill(1'b1);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd5, 0, LAST, 1'b1, 1'b0, 1'b1);

    cur_test = "gap_seq7";
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd7, 0, LAST, 1'b1, 1'b0, 1'b1);

    cur_test = "bad_port";
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, 16'd1234, 64'd8, 0, LAST, 1'b1, 1'b0, 1'b1);

    cur_test = "bad_etype";
    run(LOCAL_MAC, 16'h86DD, LOCAL_PORT, 64'd8, 0, LAST, 1'b1, 1'b0, 1'b1);

    cur_test = "wr_full_10_19";
    fill(1'b0);
    full_lo = 10; full_hi = 19;
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd8, 0, LAST, 1'b1, 1'b0, 1'b1);
    full_lo = -1; full_hi = -1;

    cur_test = "truncated_then_good";
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd99, 0, 'h100, 1'b1, 1'b0, 1'b0);
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd9, 0, LAST, 1'b1, 1'b0, 1'b1);

    cur_test = "rx_err_bcast";
    fill(1'b0);
    run(BCAST_MAC, 16'h0800, LOCAL_PORT, 64'd10, 0, LAST, 1'b1, 1'b1, 1'b1);

    cur_test = "sop_abort_then_bcast";
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd77, 0, 'h80, 1'b0, 1'b0, 1'b0);
    m_drop++;  // the abandoned frame is counted when the next sop arrives
    fill(1'b0);
    run(BCAST_MAC, 16'h0800, LOCAL_PORT, 64'd10, 0, LAST, 1'b1, 1'b0, 1'b1);

    cur_test = "sop_eop_same_byte";
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd55, 0, 0, 1'b1, 1'b0, 1'b1);

    cur_test = "long_frame";
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd11, 5, LAST + 5, 1'b1, 1'b0, 1'b1);

    cur_test = "reset_mid_payload";
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd50, 0, 'h200, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("state_before_rst", 64'(dbg_state), 64'(ST_PAYLOAD));
    chk("exp_q_drained",    64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero_outputs();
    m_seq = 64'd0; m_ok = 0; m_drop = 0; m_first = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    idle(2);

    cur_test = "after_reset_seq100";
    fill(1'b0);
    run(LOCAL_MAC, 16'h0800, LOCAL_PORT, 64'd100, 0, LAST, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
